// File: rtl/led_cmd_reg_pkg.sv
// Shared definitions for the LED command register: command encoding,
// auto-rotate state encoding and rotate-direction constants.
package ledcmd_pkg;

    typedef enum logic [2:0] {
        CMD_NONE  = 3'd0,
        CMD_LOAD  = 3'd1,
        CMD_ARITH = 3'd2,
        CMD_ROT   = 3'd3,
        CMD_AUTO  = 3'd4
    } cmd_e;

    typedef enum logic {
        AUTO_IDLE = 1'b0,
        AUTO_RUN  = 1'b1
    } auto_state_e;

    localparam logic DIR_RIGHT = 1'b0;
    localparam logic DIR_LEFT  = 1'b1;

endpackage

// File: rtl/led_cmd_reg_if.sv
// Board-side bundle of the LED command register: switch operand, debounced
// button levels and mode inputs in, LED value and carry flag out.
interface led_cmd_reg_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] swi;
    logic             btn_load;
    logic             btn_rot;
    logic             btn_add;
    logic             dir;
    logic             sub;
    logic             auto_en;
    logic [WIDTH-1:0] led;
    logic             carry;

    modport master (
        output swi, btn_load, btn_rot, btn_add, dir, sub, auto_en,
        input  led, carry
    );

    modport slave (
        input  swi, btn_load, btn_rot, btn_add, dir, sub, auto_en,
        output led, carry
    );
endinterface

// File: rtl/led_cmd_reg_edge_pulse.sv
// Rising-edge detector for one debounced button level. prev resets to 1 so a
// button already held when reset releases does not produce a pulse.
module edge_pulse (
    input  logic clk_50M,
    input  logic rst,
    input  logic level,
    output logic pulse
);
    logic prev_q;
    logic prev_d;

    always_comb begin
        prev_d = level;
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            prev_q <= 1'b1;
        end else begin
            prev_q <= prev_d;
        end
    end

    assign pulse = level & ~prev_q;
endmodule

// File: rtl/led_cmd_reg.sv
// LED register executing one load / add-sub / rotate command per button press.
// Define LEDCMD_AUTO_EN to compile in the timer-driven auto-rotate mode.
module led_cmd_reg
    import ledcmd_pkg::*;
#(
    parameter int               WIDTH    = 8,
    parameter int               ROT_STEP = 1,
    parameter int               AUTO_DIV = 25_000_000,
    parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
    input  logic         clk_50M,
    input  logic         rst,
    led_cmd_reg_if.slave bus
);
    localparam int BTN_LOAD = 0;
    localparam int BTN_ROT  = 1;
    localparam int BTN_ADD  = 2;

    logic [2:0]       btn_level;
    logic [2:0]       btn_pulse;
    logic             tick;
    cmd_e             cmd;
    logic [WIDTH-1:0] led_q,   led_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] rot_val;
    logic [WIDTH:0]   sum_val;
    logic [WIDTH:0]   diff_val;

    assign btn_level = {bus.btn_add, bus.btn_rot, bus.btn_load};

    for (genvar gi = 0; gi < 3; gi++) begin : g_edge
        edge_pulse u_edge (
            .clk_50M (clk_50M),
            .rst     (rst),
            .level   (btn_level[gi]),
            .pulse   (btn_pulse[gi])
        );
    end

`ifdef LEDCMD_AUTO_EN
    localparam int PW = $clog2(AUTO_DIV);

    auto_state_e   state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;

    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        tick    = 1'b0;
        case (state_q)
            AUTO_IDLE: begin
                presc_d = '0;
                if (bus.auto_en) state_d = AUTO_RUN;
            end
            AUTO_RUN: begin
                // Terminal count always wraps, even if a manual command steals the tick.
                if (presc_q == PW'(AUTO_DIV - 1)) begin
                    tick    = 1'b1;
                    presc_d = '0;
                end else begin
                    presc_d = presc_q + PW'(1);
                end
                if (!bus.auto_en) begin
                    state_d = AUTO_IDLE;
                    presc_d = '0;
                end
            end
            default: begin
                state_d = AUTO_IDLE;
                presc_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            state_q <= AUTO_IDLE;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
        end
    end
`else
    logic [32:0] unused_auto;
    assign unused_auto = {bus.auto_en, 32'(AUTO_DIV)};
    assign tick        = 1'b0;
`endif

    always_comb begin
        if (btn_pulse[BTN_LOAD])     cmd = CMD_LOAD;
        else if (btn_pulse[BTN_ADD]) cmd = CMD_ARITH;
        else if (btn_pulse[BTN_ROT]) cmd = CMD_ROT;
        else if (tick)               cmd = CMD_AUTO;
        else                         cmd = CMD_NONE;
    end

    always_comb begin
        if (bus.dir == DIR_LEFT) begin
            rot_val = {led_q[WIDTH-1-ROT_STEP:0], led_q[WIDTH-1:WIDTH-ROT_STEP]};
        end else begin
            rot_val = {led_q[ROT_STEP-1:0], led_q[WIDTH-1:ROT_STEP]};
        end
    end

    // The extra MSB of the difference is the borrow, set exactly when swi > led.
    assign sum_val  = {1'b0, led_q} + {1'b0, bus.swi};
    assign diff_val = {1'b0, led_q} - {1'b0, bus.swi};

    always_comb begin
        led_d   = led_q;
        carry_d = carry_q;
        case (cmd)
            CMD_LOAD:  led_d = bus.swi;
            CMD_ARITH: {carry_d, led_d} = bus.sub ? diff_val : sum_val;
            CMD_ROT,
            CMD_AUTO:  led_d = rot_val;
            default:   ;
        endcase
    end

    always_ff @(posedge clk_50M or posedge rst) begin
        if (rst) begin
            led_q   <= RST_VAL;
            carry_q <= 1'b0;
        end else begin
            led_q   <= led_d;
            carry_q <= carry_d;
        end
    end

    assign bus.led   = led_q;
    assign bus.carry = carry_q;
endmodule

// File: tb/tb_led_cmd_reg.sv
// Directed bench for led_cmd_reg (WIDTH=8, ROT_STEP=1, AUTO_DIV=4).
// Auto-rotate vectors depend on whether LEDCMD_AUTO_EN is defined.
module tb_led_cmd_reg;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    led_cmd_reg_if #(.WIDTH(8)) bus ();

    led_cmd_reg #(
        .WIDTH    (8),
        .ROT_STEP (1),
        .AUTO_DIV (4),
        .RST_VAL  (8'h00)
    ) dut (
        .clk_50M (clk),
        .rst     (rst),
        .bus     (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic step(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Raise a button for one cycle, then release and let its prev flop settle.
    task automatic press(input int which);
        case (which)
            0: bus.btn_load = 1'b1;
            1: bus.btn_rot  = 1'b1;
            default: bus.btn_add = 1'b1;
        endcase
        step(1);
        bus.btn_load = 1'b0;
        bus.btn_rot  = 1'b0;
        bus.btn_add  = 1'b0;
    endtask

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        bus.swi      = 8'hFF;
        bus.btn_load = 1'b1;
        bus.btn_rot  = 1'b0;
        bus.btn_add  = 1'b0;
        bus.dir      = 1'b0;
        bus.sub      = 1'b0;
        bus.auto_en  = 1'b0;

        // Reset state, load held through deassertion must not fire
        step(3);
        check_eq("reset_led", bus.led, 8'h00);
        check_eq("reset_carry", bus.carry, 1'b0);
        rst = 1'b0;
        step(3);
        check_eq("held_load_ignored", bus.led, 8'h00);
        bus.btn_load = 1'b0;
        step(1);

        // Load held 10 cycles fires exactly once
        bus.swi = 8'hA5;
        bus.btn_load = 1'b1;
        step(1);
        check_eq("load_a5", bus.led, 8'hA5);
        bus.swi = 8'h5A;
        step(9);
        check_eq("load_once", bus.led, 8'hA5);
        bus.btn_load = 1'b0;
        step(1);

        bus.dir = 1'b0;
        press(1);
        check_eq("rot_right", bus.led, 8'hD2);
        step(1);
        bus.dir = 1'b1;
        press(1);
        check_eq("rot_left", bus.led, 8'hA5);
        step(1);

        // Arithmetic sequence
        bus.swi = 8'hF0;
        press(0);
        step(1);
        bus.swi = 8'h20;
        bus.sub = 1'b0;
        press(2);
        check_eq("add_led", bus.led, 8'h10);
        check_eq("add_carry", bus.carry, 1'b1);
        step(1);
        bus.sub = 1'b1;
        press(2);
        check_eq("sub_borrow_led", bus.led, 8'hF0);
        check_eq("sub_borrow_carry", bus.carry, 1'b1);
        step(1);
        bus.swi = 8'h10;
        press(2);
        check_eq("sub_led", bus.led, 8'hE0);
        check_eq("sub_carry", bus.carry, 1'b0);
        step(1);
        bus.swi = 8'h30;
        bus.sub = 1'b0;
        press(2);
        check_eq("add2_led", bus.led, 8'h10);
        check_eq("add2_carry", bus.carry, 1'b1);
        step(1);

        // Coincident load/add/rot: load wins, others discarded
        bus.dir      = 1'b0;
        bus.swi      = 8'h3C;
        bus.btn_load = 1'b1;
        bus.btn_add  = 1'b1;
        bus.btn_rot  = 1'b1;
        step(1);
        check_eq("prio_led", bus.led, 8'h3C);
        check_eq("prio_carry", bus.carry, 1'b1);
        step(3);
        check_eq("prio_no_rot", bus.led, 8'h3C);
        bus.btn_load = 1'b0;
        bus.btn_add  = 1'b0;
        bus.btn_rot  = 1'b0;
        step(1);

        // Asynchronous reset mid-cycle; load rising during reset must not fire
        #3;
        rst = 1'b1;
        #1;
        check_eq("async_rst_led", bus.led, 8'h00);
        check_eq("async_rst_carry", bus.carry, 1'b0);
        bus.swi      = 8'h77;
        bus.btn_load = 1'b1;
        step(2);
        rst = 1'b0;
        step(3);
        check_eq("post_rst_no_load", bus.led, 8'h00);
        bus.btn_load = 1'b0;
        step(1);

`ifdef LEDCMD_AUTO_EN
        bus.swi = 8'h01;
        press(0);
        bus.dir     = 1'b1;
        bus.auto_en = 1'b1;
        step(1);
        step(3);
        check_eq("auto_before_tick", bus.led, 8'h01);
        step(1);
        check_eq("auto_tick1", bus.led, 8'h02);
        step(4);
        check_eq("auto_tick2", bus.led, 8'h04);
        step(3);
        bus.btn_rot = 1'b1;
        step(1);
        check_eq("auto_manual_collide", bus.led, 8'h08);
        bus.btn_rot = 1'b0;
        step(3);
        check_eq("auto_after_collide", bus.led, 8'h08);
        step(1);
        check_eq("auto_tick4", bus.led, 8'h10);
        bus.auto_en = 1'b0;
        step(10);
        check_eq("auto_off_hold", bus.led, 8'h10);
`else
        bus.swi = 8'h81;
        press(0);
        check_eq("noauto_load", bus.led, 8'h81);
        bus.dir     = 1'b1;
        bus.auto_en = 1'b1;
        step(20);
        check_eq("noauto_hold", bus.led, 8'h81);
        bus.auto_en = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/led_cmd_reg.md
# led_cmd_reg

Parametrised successor to the switch-load / rotate / add LED register. It holds a WIDTH-bit value driven onto the board LEDs and executes one command per button press. Supported commands are load, rotate by ROT_STEP, and add/subtract with a carry/borrow flag. An optional timer-driven auto-rotate mode is also available. The block sits between the debounce instances and the seven-segment/LED drivers.

## Interface
- WIDTH, 8: register and operand width, ≥2.
- ROT_STEP, 1: bits moved per rotate, 1..WIDTH-1.
- AUTO_DIV, 25_000_000: clk_50M cycles per auto-rotate step, ≥2 (0.5 s at 50 MHz).
- RST_VAL, 0: reset value of led.
- clk_50M  in  1  sole clock, all state updates on rising edge.
- rst  in  1  reset; asynchronous, active-high.
- swi  in  WIDTH  operand for load/add/sub.
- btn_load  in  1  debounced level, load command.
- btn_rot  in  1  debounced level, rotate command.
- btn_add  in  1  debounced level, add/sub command.
- dir  in  1  rotate direction: 0 right, 1 left.
- sub  in  1  0 add, 1 subtract.
- auto_en  in  1  auto-rotate enable (ignored unless LEDCMD_AUTO_EN).
- led  out  WIDTH  register value.
- carry  out  1  carry (add) / borrow (sub) of the last arithmetic command.

## Operation
- Each btn_* has its own edge detector: a prev register plus a pulse when level=1 and prev=0. A held button fires exactly once. prev resets to 1, so a button held through reset never fires.
- Load: led ← swi. carry unchanged.
- Rotate right (dir=0): led ← {led[ROT_STEP-1:0], led[WIDTH-1:ROT_STEP]}.
- Rotate left (dir=1): led ← {led[WIDTH-1-ROT_STEP:0], led[WIDTH-1:WIDTH-ROT_STEP]}.
- Rotate leaves carry unchanged.
- Add: {carry, led} ← led + swi, computed WIDTH+1 bits wide.
- Sub: led ← (led − swi) mod 2^WIDTH; carry ← 1 iff swi > led (borrow).
- Priority when pulses coincide: load > add/sub > rotate > auto step. Only the highest-priority command executes; lower-priority pulses in that cycle are discarded, not queued.
- Auto mode (macro on) has two states:
  - IDLE → AUTO when auto_en=1.
  - AUTO → IDLE when auto_en=0.
  - In AUTO, a prescaler counts 0..AUTO_DIV-1; at terminal count it wraps to 0 and rotates led by ROT_STEP in direction dir.
  - In IDLE the prescaler is held at 0.
  - If a manual command coincides with a tick, the manual command wins, the tick is lost, and the prescaler still wraps.
  - dir is sampled at each tick.
- Reset value of every output: led=RST_VAL, carry=0. Internal state on reset: prescaler=0, state=IDLE, all prev=1.
- A reset asserted mid-operation takes effect immediately, asynchronously. The first command after deassertion needs a fresh 0→1 button edge.

## Timing
- Manual commands take effect one cycle after the level rise: level high at edge k with prev low → new led/carry visible after edge k.
- No handshake and no busy flag; one command per cycle maximum.
- Auto: the first step lands AUTO_DIV edges after entering AUTO, then every AUTO_DIV edges.
- led and carry are fully registered with no combinational path from inputs.

## Configuration
- LEDCMD_AUTO_EN defined: prescaler and IDLE/AUTO FSM are compiled in and behave as above.
- LEDCMD_AUTO_EN undefined:
  - auto_en port remains but is unused.
  - No prescaler or FSM logic is generated.
  - led changes only on manual commands.
  - AUTO_DIV is ignored.

## Structure
- Shared package ledcmd_pkg holds:
  - command encoding (CMD_NONE, CMD_LOAD, CMD_ARITH, CMD_ROT, CMD_AUTO) used by the priority encoder;
  - auto state enum (AUTO_IDLE, AUTO_RUN);
  - DIR_RIGHT/DIR_LEFT constants.
- One sub-module, edge_pulse: prev flop plus rising-edge pulse, reset value 1. It is instantiated three times.

## Test plan
Bench uses WIDTH=8, ROT_STEP=1, AUTO_DIV=4, RST_VAL=0.
1. Assert rst mid-cycle → led=00 and carry=0 immediately. btn_load held through reset deassertion → no load.
2. swi=A5, btn_load held 10 cycles → led=A5 one cycle after the rise, exactly once. Then rot pulse with dir=0 → D2; rot pulse with dir=1 → A5.
3. Arithmetic sequence, in order:
   - led=F0, swi=20, add → led=10, carry=1;
   - then sub, swi=20 → led=F0, carry=1;
   - then sub, swi=10 → led=E0, carry=0.
4. btn_load, btn_add and btn_rot rise in the same cycle with swi=3C → led=3C, carry unchanged, no rotate afterwards.
5. LEDCMD_AUTO_EN on, led=01, dir=1, auto_en=1:
   - → led=02 after 4 cycles, 04 after 8;
   - manual rot pulse on a tick cycle → single rotate only;
   - auto_en=0 → led holds.
6. LEDCMD_AUTO_EN off, auto_en=1 for 20 cycles → led unchanged.
